sipo_word_deserializer: RTL

Downstream consumer of the universal shift register's serial outputs (serial_out_L / serial_out_R). It collects a qualified serial bit stream into WIDTH-bit words and presents each completed word on a valid/ready parallel port. Bit order is selectable per word. Framing errors and overflow are flagged with sticky bits. The serial source cannot be back-pressured, so the block never stalls collection.

---
 rtl/sipo_word_deserializer.sv | 86 ++++++++
 1 files changed

// File: rtl/sipo_word_deserializer.sv
// Serial-to-parallel word collector with selectable bit order, valid/ready output
// holding register, and sticky overflow / framing-error flags.
module sipo_word_deserializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ser_in,
    input  logic             ser_valid,
    input  logic             sof,
    input  logic             lsb_first,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             busy,
    output logic             overflow,
    output logic             frame_err,
    input  logic             err_clr
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t           state, state_next;
    logic [CW-1:0]    cnt, idx, cnt_next;
    logic [WIDTH-1:0] asm_q, asm_base, asm_next;
    logic             order_q, order_cur;
    logic             accept, restart, complete;

    // A sof-qualified bit always restarts at index 0; so does a wrapped count.
    always_comb begin
        restart   = ser_valid && sof;
        accept    = ser_valid && (sof || (state == COLLECT));
        idx       = restart ? '0 : cnt;
        order_cur = (idx == '0) ? lsb_first : order_q;
        asm_base  = (idx == '0) ? '0 : asm_q;
        asm_next  = order_cur ? {ser_in, asm_base[WIDTH-1:1]}
                              : {asm_base[WIDTH-2:0], ser_in};
        complete  = accept && (idx == LAST);
        cnt_next  = complete ? '0 : idx + CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (state == IDLE && restart) state_next = COLLECT;
    end

    always_comb begin
        busy = (state == COLLECT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            asm_q      <= '0;
            order_q    <= 1'b0;
            word_out   <= '0;
            word_valid <= 1'b0;
            overflow   <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (accept) begin
                cnt     <= cnt_next;
                asm_q   <= asm_next;
                order_q <= order_cur;
            end
            // A completing word may replace one being consumed on the same edge.
            if (complete && (!word_valid || word_ready)) begin
                word_out   <= asm_next;
                word_valid <= 1'b1;
            end else if (word_valid && word_ready) begin
                word_valid <= 1'b0;
            end
            overflow  <= (complete && word_valid && !word_ready) || (overflow && !err_clr);
            frame_err <= (restart && (state == COLLECT) && (cnt != '0)) || (frame_err && !err_clr);
        end
    end

endmodule
